spi_adc_ctrl: RTL

SPI_ADC_CTRL -- requirements
Module: spi_adc_ctrl

---
 rtl/spi_adc_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/spi_adc_ctrl.sv
// Multi-channel SPI command/readback controller for ADC front ends.
// One transaction at a time; outputs are flops fed from next-state values.
module spi_adc_ctrl #(
    parameter int NCH    = 2,
    parameter int WIDTH  = 16,
    parameter int RWIDTH = 8,
    parameter int DIV    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wvalid,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [NCH-1:0]    chsel,
    output logic              ready,
    output logic              err,
    output logic              rvalid,
    output logic [RWIDTH-1:0] rdata,
    output logic [NCH-1:0]    sck,
    output logic [NCH-1:0]    cs,
    output logic [NCH-1:0]    mosi,
    input  logic [NCH-1:0]    miso
);

    localparam int CW = $clog2(2 * DIV + 1);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_PH  = CW'(DIV - 1);
    localparam logic [CW-1:0] C_GAP = CW'(2 * DIV - 1);
    localparam logic [BW-1:0] B_TOP = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]     cnt, cnt_n;
    logic [1:0]        phase, phase_n;
    logic [BW-1:0]     bitidx, bitidx_n;
    logic [WIDTH-1:0]  cmd, cmd_n;
    logic [NCH-1:0]    mask, mask_n;
    logic [RWIDTH-1:0] rx, rx_n;

    logic accept;
    logic tick;
    logic miso_bit;
    logic active_n;
    logic sck_on_n;
    logic mosi_on_n;
    logic done_n;

    assign accept = wvalid && ready && (chsel != '0);

    // Readback always comes from the lowest-index selected channel.
    always_comb begin
        miso_bit = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                miso_bit = miso[i];
            end
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        phase_n  = phase;
        bitidx_n = bitidx;
        cmd_n    = cmd;
        mask_n   = mask;
        rx_n     = rx;
        tick     = (cnt == C_PH);

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SETUP;
                    cnt_n   = '0;
                    cmd_n   = wdata;
                    mask_n  = chsel;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_n  = SHIFT;
                    cnt_n    = '0;
                    phase_n  = 2'd0;
                    bitidx_n = B_TOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    cnt_n   = '0;
                    phase_n = phase + 2'd1;
                    if (phase == 2'd2) begin
                        rx_n = (rx << 1) | RWIDTH'(miso_bit);
                    end
                    if (phase == 2'd3) begin
                        if (bitidx == '0) begin
                            state_n = HOLD;
                        end else begin
                            bitidx_n = bitidx - 1'b1;
                        end
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (tick) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == C_GAP) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        active_n  = (state_n == SETUP) || (state_n == SHIFT) ||
                    (state_n == HOLD);
        sck_on_n  = (state_n == SHIFT) &&
                    ((phase_n == 2'd1) || (phase_n == 2'd2));
        mosi_on_n = (state_n == SHIFT) && cmd_n[bitidx_n];
        done_n    = (state == HOLD) && (state_n == GAP);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            phase  <= 2'd0;
            bitidx <= '0;
            cmd    <= '0;
            mask   <= '0;
            rx     <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            phase  <= phase_n;
            bitidx <= bitidx_n;
            cmd    <= cmd_n;
            mask   <= mask_n;
            rx     <= rx_n;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready  <= 1'b0;
            err    <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
            cs     <= '1;
            sck    <= '0;
            mosi   <= '0;
        end else begin
            ready  <= (state_n == IDLE);
            err    <= wvalid && !accept;
            rvalid <= done_n;
            if (done_n) begin
                rdata <= rx;
            end
            cs   <= active_n  ? ~mask_n : '1;
            sck  <= sck_on_n  ? mask_n  : '0;
            mosi <= mosi_on_n ? mask_n  : '0;
        end
    end

endmodule
